bin_div: RTL

- Iterative restoring binary divider. It is the inverse of the team's 32x32->64 multiplier.
- Takes a 2*WIDTH-bit dividend (e.g. a product) and a WIDTH-bit divisor. Returns a 2*WIDTH-bit quotient and a WIDTH-bit remainder.
- Retires one quotient bit per clock.
- Valid/ready handshakes on both the input and output sides, so it drops into the arithmetic datapath beside the multiplier.

---
 rtl/bin_div_pkg.sv | 19 +
 rtl/bin_div_lzc.sv | 20 ++
 rtl/bin_div.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bin_div_pkg.sv
// Shared types and constants for the iterative restoring divider (bin_div).
package bin_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Signed so that a size cast sign-extends it to any quotient width.
    localparam logic signed [2*DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/bin_div_lzc.sv
// Combinational leading-zero counter; count equals N when value is zero.
module bin_div_lzc #(
    parameter int N  = 64,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  value,
    output logic [CW-1:0] count
);

    // The highest set bit is visited last, so its position wins.
    always_comb begin
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (value[i]) begin
                count = CW'(N - 1 - i);
            end
        end
    end

endmodule

// File: rtl/bin_div.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional macro BIN_DIV_EARLY_TERM_EN skips the dividend's leading zeros at acceptance.
module bin_div
    import bin_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [2*WIDTH-1:0] DIV0_Q = (2*WIDTH)'(DIV0_QUOTIENT);

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   dq;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     dvs;
    logic                 dbz;

    logic [WIDTH:0]       r_shift;
    logic                 r_ge;
    logic [WIDTH-1:0]     r_sub;

    logic [2*WIDTH-1:0]   load_dq;
    logic [CW-1:0]        load_cnt;
    logic                 load_zero;

`ifdef BIN_DIV_EARLY_TERM_EN
    localparam int LZW = $clog2(2*WIDTH + 1);
    logic [LZW-1:0] lz;

    bin_div_lzc #(
        .N  (2*WIDTH),
        .CW (LZW)
    ) u_lzc (
        .value (dividend),
        .count (lz)
    );

    // A zero dividend shifts out entirely, leaving dq=0 and rem=0 for free.
    assign load_dq   = dividend << lz;
    assign load_cnt  = CW'(2*WIDTH - 1 - int'(lz));
    assign load_zero = (dividend == '0);
`else
    assign load_dq   = dividend;
    assign load_cnt  = CW'(2*WIDTH - 1);
    assign load_zero = 1'b0;
`endif

    // The partial remainder after a subtract is always below dvs, so WIDTH bits suffice.
    assign r_shift = {rem, dq[2*WIDTH-1]};
    assign r_ge    = (r_shift >= {1'b0, dvs});
    assign r_sub   = r_shift[WIDTH-1:0] - dvs;

    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0 || load_zero) begin
                        next_state = DONE;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt <= '0;
            dq  <= '0;
            rem <= '0;
            dvs <= '0;
            dbz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvs <= divisor;
                        if (divisor == '0) begin
                            dq  <= DIV0_Q;
                            rem <= dividend[WIDTH-1:0];
                            dbz <= 1'b1;
                        end else begin
                            dq  <= load_dq;
                            rem <= '0;
                            cnt <= load_cnt;
                            dbz <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    dq  <= {dq[2*WIDTH-2:0], r_ge};
                    rem <= r_ge ? r_sub : r_shift[WIDTH-1:0];
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = out_valid ? dq  : '0;
    assign remainder   = out_valid ? rem : '0;
    assign div_by_zero = out_valid & dbz;

endmodule
